// File: rtl/ame_num_approx_pkg.sv
// ---------------------------------------------------------------------------
// ame_num_approx_pkg
// Shared types and helpers for the multi-channel magnitude-exponent
// approximator.
//   ame_approx_mode_t : floor or round-to-nearest exponent selection
//   exp_width(W)      : exponent width for a W-bit lane, one extra bit so a
//                       rounded-up exponent of W still fits
// ---------------------------------------------------------------------------
package ame_num_approx_pkg;

  typedef enum logic {
    AME_APPROX_FLOOR   = 1'b0,
    AME_APPROX_NEAREST = 1'b1
  } ame_approx_mode_t;

  function automatic int exp_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/ame_num_approx_lane.sv
// ---------------------------------------------------------------------------
// ame_num_approx_lane
// One lane of the approximator: a 3-stage datapath that turns a W-bit input
// into the position of the leading one of its magnitude, optionally rounded
// up using the bit just below it.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_en            : global pipeline advance enable
//   i_stageValid[0] : beat accepted into stage 1 this cycle
//   i_stageValid[1] : stage 1 holds a valid beat (moves into stage 2)
//   i_stageValid[2] : stage 2 holds a valid beat (moves into stage 3)
//   i_mode          : floor / nearest, travels with the beat
//   i_data          : lane input word
//   o_exp           : exponent (zero-extended to EW bits)
//   o_zero          : magnitude was zero
//   o_sign          : input was negative
// ---------------------------------------------------------------------------
module ame_num_approx_lane
  import ame_num_approx_pkg::*;
#(
  parameter int W         = 64,
  parameter bit SIGNED_IN = 1'b1,
  parameter int EW        = exp_width(W)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [2:0]       i_stageValid,
  input  ame_approx_mode_t i_mode,
  input  logic [W-1:0]     i_data,
  output logic [EW-1:0]    o_exp,
  output logic             o_zero,
  output logic             o_sign
);

  logic             w_neg;
  logic [W-1:0]     w_mag;
  logic [W-1:0]     r_mag1;
  logic             r_sign1;
  ame_approx_mode_t r_mode1;

  logic [W-1:0]     w_oneHot;
  logic             w_guard;
  logic [W-1:0]     r_oneHot2;
  logic             r_guard2;
  logic             r_sign2;
  ame_approx_mode_t r_mode2;

  logic [EW-1:0]    w_pos;
  logic             w_inc;
  logic [EW-1:0]    r_pos3;
  logic             r_inc3;
  logic             r_zero3;
  logic             r_sign3;

  // The most negative input negates to itself, which read as unsigned is
  // exactly 2^(W-1), so no special case is needed.
  assign w_neg = SIGNED_IN && i_data[W-1];
  assign w_mag = w_neg ? -i_data : i_data;

  // Stage 1: magnitude, sign and mode
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mag1  <= '0;
      r_sign1 <= 1'b0;
      r_mode1 <= AME_APPROX_FLOOR;
    end else if (i_en && i_stageValid[0]) begin
      r_mag1  <= w_mag;
      r_sign1 <= w_neg;
      r_mode1 <= i_mode;
    end
  end

  // Keep only the highest set bit, scanning down from the MSB
  always_comb begin : leadOne
    logic found;
    found    = 1'b0;
    w_oneHot = '0;
    for (int i = W - 1; i >= 0; i--) begin
      w_oneHot[i] = r_mag1[i] & ~found;
      found       = found | r_mag1[i];
    end
  end

  // Shifting the one-hot down one place selects the bit below the leading
  // one; a leading one at bit 0 (or no one at all) yields a zero guard.
  assign w_guard = |((w_oneHot >> 1) & r_mag1);

  // Stage 2: one-hot leading-one vector and guard bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_oneHot2 <= '0;
      r_guard2  <= 1'b0;
      r_sign2   <= 1'b0;
      r_mode2   <= AME_APPROX_FLOOR;
    end else if (i_en && i_stageValid[1]) begin
      r_oneHot2 <= w_oneHot;
      r_guard2  <= w_guard;
      r_sign2   <= r_sign1;
      r_mode2   <= r_mode1;
    end
  end

  // One-hot to binary: OR together the indices of set bits (at most one)
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (r_oneHot2[i]) begin
        w_pos = w_pos | EW'(i);
      end
    end
  end

  assign w_inc = (r_mode2 == AME_APPROX_NEAREST) && r_guard2;

  // Stage 3: encoded position, round increment, zero flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pos3  <= '0;
      r_inc3  <= 1'b0;
      r_zero3 <= 1'b0;
      r_sign3 <= 1'b0;
    end else if (i_en && i_stageValid[2]) begin
      r_pos3  <= w_pos;
      r_inc3  <= w_inc;
      r_zero3 <= ~|r_oneHot2;
      r_sign3 <= r_sign2;
    end
  end

  // EW has one spare bit, so the increment never overflows
  assign o_exp  = r_pos3 + EW'(r_inc3);
  assign o_zero = r_zero3;
  assign o_sign = r_sign3;

endmodule

// File: rtl/ame_num_approx_mc.sv
// ---------------------------------------------------------------------------
// ame_num_approx_mc
// Multi-channel pipelined magnitude-exponent approximator. COMP_CHANNELS lanes
// run in lockstep behind one valid/ready handshake with full backpressure and
// a fixed 3-cycle latency.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   comp_valid_i  : input beat valid
//   comp_ready_o  : input beat accepted when high with comp_valid_i
//   comp_mode_i   : 0 = floor, 1 = round-to-nearest, sampled with the beat
//   comp_data_i   : lane k at [k*W +: W]
//   comp_valid_o  : output beat valid
//   comp_ready_i  : downstream accepts the output beat
//   comp_data_o   : lane k exponent at [k*EW +: EW]
//   comp_zero_o   : per-lane zero-magnitude flag
//   comp_sign_o   : per-lane negative-input flag
// ---------------------------------------------------------------------------
module ame_num_approx_mc
  import ame_num_approx_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int COMP_CHANNELS  = 4,
  parameter int COMP_SIGNED    = 1
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_i,
  input  logic                                                 comp_valid_i,
  output logic                                                 comp_ready_o,
  input  logic                                                 comp_mode_i,
  input  logic [COMP_CHANNELS*COMP_DATA_BITS-1:0]              comp_data_i,
  output logic                                                 comp_valid_o,
  input  logic                                                 comp_ready_i,
  output logic [COMP_CHANNELS*exp_width(COMP_DATA_BITS)-1:0]   comp_data_o,
  output logic [COMP_CHANNELS-1:0]                             comp_zero_o,
  output logic [COMP_CHANNELS-1:0]                             comp_sign_o
);

  localparam int W  = COMP_DATA_BITS;
  localparam int EW = exp_width(COMP_DATA_BITS);

  logic             r_rstDone;
  logic             r_valid1;
  logic             r_valid2;
  logic             r_valid3;
  logic             w_en;
  logic             w_accept;
  ame_approx_mode_t w_mode;

  // The whole pipeline advances together unless the output is stalled
  assign w_en         = !r_valid3 || comp_ready_i;
  assign comp_ready_o = w_en && r_rstDone;
  assign w_accept     = comp_valid_i && comp_ready_o;
  assign w_mode       = ame_approx_mode_t'(comp_mode_i);
  assign comp_valid_o = r_valid3;

  // r_rstDone keeps ready low for the first cycle after reset release;
  // the valid chain shifts only on the global enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rstDone <= 1'b0;
      r_valid1  <= 1'b0;
      r_valid2  <= 1'b0;
      r_valid3  <= 1'b0;
    end else begin
      r_rstDone <= 1'b1;
      if (w_en) begin
        r_valid1 <= w_accept;
        r_valid2 <= r_valid1;
        r_valid3 <= r_valid2;
      end
    end
  end

  for (genvar k = 0; k < COMP_CHANNELS; k++) begin : g_lane
    ame_num_approx_lane #(
      .W         (W),
      .SIGNED_IN (COMP_SIGNED != 0),
      .EW        (EW)
    ) u_lane (
      .i_clk        (clk_i),
      .i_rst        (rst_i),
      .i_en         (w_en),
      .i_stageValid ({r_valid2, r_valid1, w_accept}),
      .i_mode       (w_mode),
      .i_data       (comp_data_i[k*W +: W]),
      .o_exp        (comp_data_o[k*EW +: EW]),
      .o_zero       (comp_zero_o[k]),
      .o_sign       (comp_sign_o[k])
    );
  end

endmodule

// File: tb/tb_ame_num_approx_mc.sv
// ---------------------------------------------------------------------------
// tb_ame_num_approx_mc
// Drives a signed and an unsigned 4x64-bit build of ame_num_approx_mc from the
// same inputs. Directed vectors carry hand-computed exponents; streaming
// sequences exercise backpressure, throughput and mid-stream reset against a
// small per-lane reference model.
// ---------------------------------------------------------------------------
module tb_ame_num_approx_mc;

  localparam int W  = 64;
  localparam int CH = 4;
  localparam int EW = 7;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             compValidI;
  logic             compReadyO;
  logic             compModeI;
  logic [CH*W-1:0]  compDataI;
  logic             compValidO;
  logic             compReadyI;
  logic [CH*EW-1:0] compDataO;
  logic [CH-1:0]    compZeroO;
  logic [CH-1:0]    compSignO;

  logic             uReadyO;
  logic             uValidO;
  logic [CH*EW-1:0] uDataO;
  logic [CH-1:0]    uZeroO;
  logic [CH-1:0]    uSignO;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic             mode;
    logic [CH*W-1:0]  data;
    logic [CH*EW-1:0] expS;
    logic [CH-1:0]    zero;
    logic [CH-1:0]    sign;
    logic [CH*EW-1:0] expU;
  } vec_t;

  vec_t            vecs[8];
  logic [CH*W-1:0] beatData[100];
  logic            beatMode[100];

  always #5 clk_i = ~clk_i;

  ame_num_approx_mc #(
    .COMP_DATA_BITS (W),
    .COMP_CHANNELS  (CH),
    .COMP_SIGNED    (1)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .comp_valid_i (compValidI),
    .comp_ready_o (compReadyO),
    .comp_mode_i  (compModeI),
    .comp_data_i  (compDataI),
    .comp_valid_o (compValidO),
    .comp_ready_i (compReadyI),
    .comp_data_o  (compDataO),
    .comp_zero_o  (compZeroO),
    .comp_sign_o  (compSignO)
  );

  ame_num_approx_mc #(
    .COMP_DATA_BITS (W),
    .COMP_CHANNELS  (CH),
    .COMP_SIGNED    (0)
  ) dutU (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .comp_valid_i (compValidI),
    .comp_ready_o (uReadyO),
    .comp_mode_i  (compModeI),
    .comp_data_i  (compDataI),
    .comp_valid_o (uValidO),
    .comp_ready_i (compReadyI),
    .comp_data_o  (uDataO),
    .comp_zero_o  (uZeroO),
    .comp_sign_o  (uSignO)
  );

  // Compare one observed value against its required value
  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference for one lane: {exponent[6:0], zero, sign}
  function automatic logic [8:0] refLane(input logic [63:0] x, input bit sgn, input bit nearest);
    logic [63:0] m;
    logic        s;
    int          p;
    s = sgn && x[63];
    m = s ? (~x + 64'd1) : x;
    if (m == 64'd0) return {7'd0, 1'b1, 1'b0};
    p = 63;
    while (!m[p]) p--;
    if (nearest && p >= 1 && m[p-1]) p++;
    return {7'(p), 1'b0, s};
  endfunction

  // Reference for a whole beat: {exponents, zero flags, sign flags}
  function automatic logic [35:0] refBeat(input logic [CH*W-1:0] d, input bit sgn, input bit nearest);
    logic [27:0] e;
    logic [3:0]  z;
    logic [3:0]  s;
    logic [8:0]  r;
    for (int k = 0; k < CH; k++) begin
      r = refLane(d[k*W +: W], sgn, nearest);
      e[k*EW +: EW] = r[8:2];
      z[k] = r[1];
      s[k] = r[0];
    end
    return {e, z, s};
  endfunction

  // Send one directed vector and check handshake timing and lane results.
  // Called at a negedge with comp_ready_i high; returns at a negedge.
  task automatic applyStimulus(input vec_t v, input int idx);
    compValidI = 1'b1;
    compDataI  = v.data;
    compModeI  = v.mode;
    #1;
    checkOutput($sformatf("vec%0d ready_o", idx), compReadyO, 1);
    @(negedge clk_i);
    compValidI = 1'b0;
    checkOutput($sformatf("vec%0d valid_o +1", idx), compValidO, 0);
    @(negedge clk_i);
    checkOutput($sformatf("vec%0d valid_o +2", idx), compValidO, 0);
    @(negedge clk_i);
    checkOutput($sformatf("vec%0d valid_o +3", idx), compValidO, 1);
    checkOutput($sformatf("vec%0d exp", idx), compDataO, v.expS);
    checkOutput($sformatf("vec%0d zero", idx), compZeroO, v.zero);
    checkOutput($sformatf("vec%0d sign", idx), compSignO, v.sign);
    checkOutput($sformatf("vec%0d unsigned exp", idx), uDataO, v.expU);
    checkOutput($sformatf("vec%0d unsigned sign", idx), uSignO, 0);
  endtask

  // Stream n beats through the signed build, optionally with random
  // downstream stalls, scoreboarding every output. Called at a negedge.
  task automatic runStream(input int n, input bit randReady, input int budget,
                           output int cycles, output int got);
    logic [35:0] q[$];
    logic [36:0] prevOut;
    logic [35:0] expect_;
    bit          prevStall;
    bit          accPrev;
    int          idx;
    prevStall = 0;
    accPrev   = 0;
    prevOut   = '0;
    idx       = 0;
    got       = 0;
    cycles    = 0;
    compValidI = 1'b1;
    compDataI  = beatData[0];
    compModeI  = beatMode[0];
    while (got < n && cycles < budget) begin
      if (accPrev) begin
        idx++;
        if (idx < n) begin
          compDataI = beatData[idx];
          compModeI = beatMode[idx];
        end else begin
          compValidI = 1'b0;
        end
      end
      compReadyI = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checkOutput($sformatf("ready_o cycle %0d", cycles), compReadyO, !(compValidO && !compReadyI));
      if (prevStall)
        checkOutput($sformatf("hold cycle %0d", cycles),
                    {compValidO, compDataO, compZeroO, compSignO}, prevOut);
      if (compValidO && compReadyI) begin
        if (q.size() == 0) begin
          checkOutput("spurious output beat", q.size(), 1);
        end else begin
          expect_ = q.pop_front();
          checkOutput($sformatf("stream beat %0d", got), {compDataO, compZeroO, compSignO}, expect_);
        end
        got++;
      end
      accPrev = compValidI && compReadyO;
      if (accPrev) q.push_back(refBeat(compDataI, 1'b1, compModeI));
      prevStall = compValidO && !compReadyI;
      prevOut   = {compValidO, compDataO, compZeroO, compSignO};
      cycles++;
      @(negedge clk_i);
    end
    compValidI = 1'b0;
    compReadyI = 1'b1;
  endtask

  task automatic genBeats(input int n);
    logic [63:0] x;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < CH; k++) begin
        x = {$urandom, $urandom} >> $urandom_range(0, 63);
        if ($urandom_range(0, 3) == 0) x = -x;
        if ($urandom_range(0, 9) == 0) x = 64'd0;
        beatData[b][k*W +: W] = x;
      end
      beatMode[b] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int  cyc;
    int  got;
    bit  sawValid;

    // Directed vectors, lane 0 rightmost; expected exponents hand-computed
    vecs[0] = '{mode: 1'b0,
                data: {64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1},
                expS: {7'd63, 7'd0, 7'd0, 7'd0}, zero: 4'b0100, sign: 4'b1010,
                expU: {7'd63, 7'd0, 7'd63, 7'd0}};
    vecs[1] = '{mode: 1'b1,
                data: {64'hFFFF_FFFF_FFFF_FFF4, 64'd6, 64'd5, 64'd3},
                expS: {7'd4, 7'd3, 7'd2, 7'd2}, zero: 4'b0000, sign: 4'b1000,
                expU: {7'd64, 7'd3, 7'd2, 7'd2}};
    vecs[2] = '{mode: 1'b0,
                data: {64'hFFFF_FFFF_FFFF_FFF4, 64'd6, 64'd5, 64'd3},
                expS: {7'd3, 7'd2, 7'd2, 7'd1}, zero: 4'b0000, sign: 4'b1000,
                expU: {7'd63, 7'd2, 7'd2, 7'd1}};
    vecs[3] = '{mode: 1'b1,
                data: {64'd0, 64'd2, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF},
                expS: {7'd0, 7'd1, 7'd63, 7'd63}, zero: 4'b1000, sign: 4'b0010,
                expU: {7'd0, 7'd1, 7'd63, 7'd63}};
    vecs[4] = '{mode: 1'b1,
                data: {64'd7, 64'h0000_0180_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF},
                expS: {7'd3, 7'd41, 7'd2, 7'd0}, zero: 4'b0000, sign: 4'b0011,
                expU: {7'd3, 7'd41, 7'd64, 7'd64}};
    vecs[5] = '{mode: 1'b1, data: {4{64'hFFFF_FFFF_FFFF_FFFF}},
                expS: {4{7'd0}}, zero: 4'b0000, sign: 4'b1111, expU: {4{7'd64}}};
    vecs[6] = '{mode: 1'b0, data: {4{64'hFFFF_FFFF_FFFF_FFFF}},
                expS: {4{7'd0}}, zero: 4'b0000, sign: 4'b1111, expU: {4{7'd63}}};
    vecs[7] = '{mode: 1'b1,
                data: {64'h4000_0000_0000_0000, 64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3},
                expS: {7'd62, 7'd4, 7'd4, 7'd2}, zero: 4'b0000, sign: 4'b0010,
                expU: {7'd62, 7'd4, 7'd64, 7'd2}};

    rst_i      = 1'b1;
    compValidI = 1'b0;
    compReadyI = 1'b1;
    compModeI  = 1'b0;
    compDataI  = '0;

    // Power-on reset
    repeat (2) @(negedge clk_i);
    checkOutput("reset valid_o", compValidO, 0);
    checkOutput("reset data_o", compDataO, 0);
    checkOutput("reset zero_o", compZeroO, 0);
    checkOutput("reset sign_o", compSignO, 0);
    checkOutput("reset ready_o", compReadyO, 0);
    rst_i = 1'b0;
    #1;
    checkOutput("ready_o at release", compReadyO, 0);
    @(negedge clk_i);
    checkOutput("ready_o after release", compReadyO, 1);

    // Directed vectors
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Reset with two beats in flight, asserted between clock edges
    compValidI = 1'b1;
    compDataI  = vecs[1].data;
    compModeI  = vecs[1].mode;
    @(negedge clk_i);
    compDataI  = vecs[3].data;
    compModeI  = vecs[3].mode;
    @(negedge clk_i);
    compValidI = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    checkOutput("midreset valid_o", compValidO, 0);
    checkOutput("midreset data_o", compDataO, 0);
    checkOutput("midreset zero_o", compZeroO, 0);
    checkOutput("midreset sign_o", compSignO, 0);
    checkOutput("midreset ready_o", compReadyO, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("midreset ready_o at release", compReadyO, 0);
    @(negedge clk_i);
    checkOutput("midreset ready_o after release", compReadyO, 1);
    sawValid = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (compValidO) sawValid = 1;
    end
    checkOutput("no output from flushed beats", sawValid, 0);

    // Backpressure: 10 back-to-back beats with random downstream stalls
    genBeats(10);
    runStream(10, 1'b1, 300, cyc, got);
    checkOutput("backpressure beats delivered", got, 10);

    // Throughput: 100 beats with downstream always ready
    genBeats(100);
    runStream(100, 1'b0, 200, cyc, got);
    checkOutput("throughput beats delivered", got, 100);
    checkOutput("throughput cycles", cyc, 103);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
